game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter BLOCK_H, default 60: falling block height in lines.
REQ-002 Parameter SPEED, default 4: lines moved per frame tick.
REQ-003 Parameter HIT_TOP, default 620, and HIT_BOT, default 650: hit-zone rows, HIT_TOP inclusive, HIT_BOT exclusive.
REQ-004 Parameter SCREEN_BOT, default 720: bottom row.
REQ-005 Parameter WIN_SCORE, default 10: points needed to win.
REQ-006 Parameter RES_STEP, default 36: score-bar lines added per point.
REQ-007 clk input 1: single system clock; all state on rising edge.
REQ-008 rst input 1: asynchronous, active-high reset.
REQ-009 frame_tick input 1: one-cycle pulse per video frame.
REQ-010 start input 1: one-cycle pulse that begins or restarts a round.
REQ-011 btn1, btn2 input 1 each: player buttons; levels already synchronised to clk.
REQ-012 block1_top, block1_bot, block2_top, block2_bot output 10 each: lane block rows, registered.
REQ-013 res1_top, res2_top output 10 each: score-bar top rows, registered.
REQ-014 winner output 2: 0 = playing or idle, 1 = P1, 2 = P2, 3 = tie; registered.

Function
REQ-015 FSM states: IDLE, PLAY, OVER.
REQ-016 IDLE: block tops and bots = 0, which hides the blocks. res tops = SCREEN_BOT. winner = 0.
REQ-017 IDLE to PLAY on start: scores cleared; each block set to top 0, bot BLOCK_H.
REQ-018 PLAY movement: on frame_tick, each lane's top and bot increase by SPEED.
REQ-019 Block arithmetic: use 11-bit internal sums; outputs always hold values of at most SCREEN_BOT.
REQ-020 Button edges: a press is a rising edge of btnN, detected by an internal previous-value register.
  - A held button yields exactly one press.
REQ-021 Hit: a press while bot > HIT_TOP and top < HIT_BOT.
  - Next cycle: scoreN increments by 1 and that block respawns at top 0, bot BLOCK_H.
REQ-022 Press outside the hit zone: ignored, with no penalty.
REQ-023 Miss: if a tick would make top ≥ SCREEN_BOT, the block respawns at 0/BLOCK_H and the score is unchanged.
REQ-024 Hit and frame_tick in the same cycle: the hit wins; the block respawns and does not move this cycle.
REQ-025 Lanes are fully independent; both lanes may score in the same cycle.
REQ-026 Score width: 4 bits, saturating at WIN_SCORE.
REQ-027 Score bars: resN_top = SCREEN_BOT − scoreN × RES_STEP, updated in the same cycle as the score register.
REQ-028 PLAY to OVER: in the cycle a score reaches WIN_SCORE, winner is set.
  - winner = 1 or 2 for a single winner.
  - winner = 3 if both scores reach WIN_SCORE in the same cycle.
REQ-029 OVER behaviour:
  - Blocks frozen; buttons and frame_tick ignored.
  - winner and res tops held.
REQ-030 start in OVER: go to PLAY with the same actions as REQ-017 and winner = 0.
REQ-031 start in PLAY: restart the round per REQ-017; the state stays PLAY.
REQ-032 Hit-window latency: a score change appears on outputs 1 cycle after the press cycle.

Reset
REQ-033 rst asserted at any time, including mid-round: state = IDLE, scores = 0, button-history registers = 0, all outputs at the IDLE values of REQ-016, immediately and without waiting for a clock edge.
REQ-034 After rst deasserts, the block remains in IDLE until a start pulse.

Verification
REQ-035 Start, then 141 ticks, then a btn1 edge:
  - Before the press: block1 = 564/624.
  - After the press: block1 = 0/60, res1_top = 684.
REQ-036 Start, then 163 ticks, then a btn1 edge:
  - The press is ignored.
  - score1 = 0 and res1_top = 720.
  - At tick 180, block1 respawns to 0/60.
REQ-037 btn2 held high for 50 cycles inside the hit window gives exactly one point: res2_top = 684.
REQ-038 Force both scores to 9; hit both lanes in the same cycle: winner = 3, state OVER, res tops = 360; later ticks do not move the blocks.
REQ-039 btn1 press coinciding with frame_tick at tick 150: block1 = 0/60, not 4/64.
REQ-040 rst pulsed mid-round with score1 = 5: outputs return to zero blocks, res tops 720, winner 0 asynchronously; a start afterwards begins a fresh round.

Source files
------------

// File: rtl/game_ctrl.sv
// Two-lane rhythm game controller.
// A falling block moves down each lane on every frame tick. A button press
// while the block overlaps the hit zone scores a point and respawns the block.
// The first lane to reach WIN_SCORE ends the round. If both lanes reach it in
// the same cycle, the round ends in a tie.
module game_ctrl #(
  parameter int BLOCK_H    = 60,
  parameter int SPEED      = 4,
  parameter int HIT_TOP    = 620,
  parameter int HIT_BOT    = 650,
  parameter int SCREEN_BOT = 720,
  parameter int WIN_SCORE  = 10,
  parameter int RES_STEP   = 36
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       btn1,
  input  logic       btn2,
  output logic [9:0] block1_top,
  output logic [9:0] block1_bot,
  output logic [9:0] block2_top,
  output logic [9:0] block2_bot,
  output logic [9:0] res1_top,
  output logic [9:0] res2_top,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  localparam logic [10:0] H11  = 11'(BLOCK_H);
  localparam logic [10:0] SP11 = 11'(SPEED);
  localparam logic [10:0] HT11 = 11'(HIT_TOP);
  localparam logic [10:0] HB11 = 11'(HIT_BOT);
  localparam logic [10:0] SB11 = 11'(SCREEN_BOT);
  localparam logic [10:0] RS11 = 11'(RES_STEP);
  localparam logic [9:0]  SB10 = 10'(SCREEN_BOT);
  localparam logic [9:0]  H10  = 10'(BLOCK_H);
  localparam logic [3:0]  WIN4 = 4'(WIN_SCORE);

  state_t          state_q;
  logic [1:0][9:0] top_q, bot_q, res_q;
  logic [1:0][3:0] score_q;
  logic [1:0]      btnPrev_q;
  logic [1:0]      winner_q;

  logic [1:0]      press, hit, miss, win;
  logic [1:0][9:0] movTop, movBot, resNext;
  logic [1:0][3:0] scoreInc;
  logic [10:0]     sumTop, sumBot, prod;

  // Per-lane next values: press edges, hit test, moved/clamped block, bumped score
  always_comb begin
    press    = {btn2, btn1} & ~btnPrev_q;
    hit      = '0;
    miss     = '0;
    win      = '0;
    movTop   = '0;
    movBot   = '0;
    resNext  = '0;
    scoreInc = '0;
    sumTop   = '0;
    sumBot   = '0;
    prod     = '0;
    for (int i = 0; i < 2; i++) begin
      hit[i]      = press[i] && ({1'b0, bot_q[i]} > HT11) && ({1'b0, top_q[i]} < HB11);
      sumTop      = {1'b0, top_q[i]} + SP11;
      sumBot      = sumTop + H11;
      miss[i]     = (sumTop >= SB11);
      movTop[i]   = sumTop[9:0];
      movBot[i]   = (sumBot > SB11) ? SB10 : sumBot[9:0];
      scoreInc[i] = (score_q[i] >= WIN4) ? score_q[i] : score_q[i] + 4'd1;
      prod        = 11'(scoreInc[i]) * RS11;
      resNext[i]  = 10'(SB11 - prod);
      win[i]      = hit[i] && (scoreInc[i] == WIN4);
    end
  end

  // Round state machine together with lane positions, scores and score bars
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      btnPrev_q <= '0;
      winner_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        top_q[i]   <= '0;
        bot_q[i]   <= '0;
        score_q[i] <= '0;
        res_q[i]   <= SB10;
      end
    end else begin
      btnPrev_q <= {btn2, btn1};
      case (state_q)
        IDLE, OVER: begin
          if (start) begin
            state_q  <= PLAY;
            winner_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
              top_q[i]   <= '0;
              bot_q[i]   <= H10;
              score_q[i] <= '0;
              res_q[i]   <= SB10;
            end
          end
        end
        PLAY: begin
          if (start) begin
            winner_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
              top_q[i]   <= '0;
              bot_q[i]   <= H10;
              score_q[i] <= '0;
              res_q[i]   <= SB10;
            end
          end else begin
            for (int i = 0; i < 2; i++) begin
              if (hit[i]) begin
                score_q[i] <= scoreInc[i];
                res_q[i]   <= resNext[i];
                top_q[i]   <= '0;
                bot_q[i]   <= H10;
              end else if (frame_tick) begin
                if (miss[i]) begin
                  top_q[i] <= '0;
                  bot_q[i] <= H10;
                end else begin
                  top_q[i] <= movTop[i];
                  bot_q[i] <= movBot[i];
                end
              end
            end
            if (|win) begin
              state_q  <= OVER;
              winner_q <= win;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign block1_top = top_q[0];
  assign block1_bot = bot_q[0];
  assign block2_top = top_q[1];
  assign block2_bot = bot_q[1];
  assign res1_top   = res_q[0];
  assign res2_top   = res_q[1];
  assign winner     = winner_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Testbench for game_ctrl.
// Stimulus pushes the expected post-edge outputs, taken from a rule-level game
// model, into a queue. A monitor pops one entry after each clock edge and
// compares it against the DUT outputs.
module tb_game_ctrl;

  localparam int BLOCK_H = 60, SPEED = 4, HIT_TOP = 620, HIT_BOT = 650;
  localparam int SCREEN_BOT = 720, WIN_SCORE = 10, RES_STEP = 36;

  logic clk = 1'b0, rst = 1'b1;
  logic frame_tick = 1'b0, start = 1'b0, btn1 = 1'b0, btn2 = 1'b0;
  logic [9:0] block1_top, block1_bot, block2_top, block2_bot, res1_top, res2_top;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;
  int cycleNo = 0;

  logic [61:0] expQ[$];

  // Model state: mode 0 idle, 1 playing, 2 finished
  int mMode;
  int mPos[2];
  int mScore[2];
  bit mPrev[2];
  int mWin;

  game_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .btn1(btn1), .btn2(btn2),
    .block1_top(block1_top), .block1_bot(block1_bot),
    .block2_top(block2_top), .block2_bot(block2_bot),
    .res1_top(res1_top), .res2_top(res2_top), .winner(winner)
  );

  always #5 clk = ~clk;

  function automatic int minInt(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic modelReset();
    mMode = 0; mWin = 0;
    for (int i = 0; i < 2; i++) begin
      mPos[i] = 0; mScore[i] = 0; mPrev[i] = 0;
    end
  endtask

  task automatic modelNewRound();
    mMode = 1; mWin = 0;
    for (int i = 0; i < 2; i++) begin
      mPos[i] = 0; mScore[i] = 0;
    end
  endtask

  // One clock edge of the game rules
  task automatic modelStep(input bit st, input bit ft, input bit b1, input bit b2);
    bit b[2];
    bit pr[2];
    bit won[2];
    b[0] = b1; b[1] = b2;
    for (int i = 0; i < 2; i++) begin
      pr[i] = b[i] && !mPrev[i];
      mPrev[i] = b[i];
      won[i] = 0;
    end
    if (st) begin
      modelNewRound();
    end else if (mMode == 1) begin
      for (int i = 0; i < 2; i++) begin
        int bot;
        bot = minInt(mPos[i] + BLOCK_H, SCREEN_BOT);
        if (pr[i] && bot > HIT_TOP && mPos[i] < HIT_BOT) begin
          mScore[i] = minInt(mScore[i] + 1, WIN_SCORE);
          mPos[i] = 0;
          if (mScore[i] == WIN_SCORE) won[i] = 1;
        end else if (ft) begin
          mPos[i] = (mPos[i] + SPEED >= SCREEN_BOT) ? 0 : mPos[i] + SPEED;
        end
      end
      if (won[0] || won[1]) begin
        mMode = 2;
        mWin = int'(won[0]) + 2 * int'(won[1]);
      end
    end
  endtask

  function automatic logic [61:0] modelOut();
    int t[2], bt[2], r[2];
    for (int i = 0; i < 2; i++) begin
      if (mMode == 0) begin
        t[i] = 0; bt[i] = 0; r[i] = SCREEN_BOT;
      end else begin
        t[i] = mPos[i];
        bt[i] = minInt(mPos[i] + BLOCK_H, SCREEN_BOT);
        r[i] = SCREEN_BOT - mScore[i] * RES_STEP;
      end
    end
    return {10'(t[0]), 10'(bt[0]), 10'(t[1]), 10'(bt[1]), 10'(r[0]), 10'(r[1]), 2'(mWin)};
  endfunction

  // Monitor: after each edge, compare DUT outputs with the oldest expectation
  always @(posedge clk) begin
    logic [61:0] e, a;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      a = {block1_top, block1_bot, block2_top, block2_bot, res1_top, res2_top, winner};
      checks++;
      if (a !== e) begin
        errors++;
        $display("[TB] FAIL cycle%0d outputs: actual b1=%0d/%0d b2=%0d/%0d res=%0d/%0d win=%0d required b1=%0d/%0d b2=%0d/%0d res=%0d/%0d win=%0d",
                 cycleNo, a[61:52], a[51:42], a[41:32], a[31:22], a[21:12], a[11:2], a[1:0],
                 e[61:52], e[51:42], e[41:32], e[31:22], e[21:12], e[11:2], e[1:0]);
      end
    end
  end

  // Drive one cycle of inputs, record the expected result, return after the check
  task automatic applyStimulus(input bit st, input bit ft, input bit b1, input bit b2);
    start = st; frame_tick = ft; btn1 = b1; btn2 = b2;
    modelStep(st, ft, b1, b2);
    expQ.push_back(modelOut());
    @(posedge clk);
    #2;
    cycleNo++;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) applyStimulus(0, 1, 0, 0);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_b1top"}, block1_top, 0);
    checkOutput({tag, "_b1bot"}, block1_bot, 0);
    checkOutput({tag, "_b2bot"}, block2_bot, 0);
    checkOutput({tag, "_res1"}, res1_top, SCREEN_BOT);
    checkOutput({tag, "_res2"}, res2_top, SCREEN_BOT);
    checkOutput({tag, "_win"}, winner, 0);
  endtask

  task automatic asyncReset(input string tag);
    rst = 1'b1;
    #1;
    checkIdleOutputs(tag);
    modelReset();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    modelReset();
    #12;
    checkIdleOutputs("reset");
    @(posedge clk);
    #2;
    rst = 1'b0;
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 0, 1);

    // Hit inside the zone
    applyStimulus(1, 0, 0, 0);
    checkOutput("start_b1bot", block1_bot, BLOCK_H);
    ticks(141);
    checkOutput("pre_hit_top", block1_top, 564);
    checkOutput("pre_hit_bot", block1_bot, 624);
    applyStimulus(0, 0, 1, 0);
    checkOutput("hit_top", block1_top, 0);
    checkOutput("hit_bot", block1_bot, 60);
    checkOutput("hit_res1", res1_top, 684);
    applyStimulus(0, 0, 0, 0);

    // Press past the zone is ignored, then the block misses off the bottom
    applyStimulus(1, 0, 0, 0);
    ticks(163);
    applyStimulus(0, 0, 1, 0);
    checkOutput("late_res1", res1_top, 720);
    checkOutput("late_top", block1_top, 652);
    applyStimulus(0, 0, 0, 0);
    ticks(16);
    checkOutput("clamp_top", block1_top, 716);
    checkOutput("clamp_bot", block1_bot, 720);
    ticks(1);
    checkOutput("miss_top", block1_top, 0);
    checkOutput("miss_bot", block1_bot, 60);

    // Held button scores once
    applyStimulus(1, 0, 0, 0);
    ticks(141);
    repeat (50) applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("held_res2", res2_top, 684);

    // Press coinciding with a tick
    applyStimulus(1, 0, 0, 0);
    ticks(149);
    applyStimulus(0, 1, 1, 0);
    checkOutput("tick_hit_top", block1_top, 0);
    checkOutput("tick_hit_bot", block1_bot, 60);
    checkOutput("tick_other_top", block2_top, 600);
    applyStimulus(0, 0, 0, 0);

    // Both lanes to nine, then a simultaneous winning hit
    applyStimulus(1, 0, 0, 0);
    repeat (10) begin
      ticks(141);
      applyStimulus(0, 0, 1, 1);
      applyStimulus(0, 0, 0, 0);
    end
    checkOutput("tie_winner", winner, 3);
    checkOutput("tie_res1", res1_top, 360);
    checkOutput("tie_res2", res2_top, 360);
    ticks(5);
    applyStimulus(0, 0, 1, 1);
    checkOutput("over_top1", block1_top, 0);
    checkOutput("over_bot2", block2_bot, 60);
    checkOutput("over_winner", winner, 3);
    applyStimulus(1, 0, 0, 0);
    checkOutput("restart_winner", winner, 0);
    checkOutput("restart_res1", res1_top, 720);

    // Mid-round reset with score1 at five
    repeat (5) begin
      ticks(141);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0);
    end
    checkOutput("five_res1", res1_top, 540);
    ticks(20);
    asyncReset("midrst");
    applyStimulus(0, 1, 0, 0);
    checkOutput("post_rst_idle", block1_bot, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("fresh_bot", block1_bot, 60);
    checkOutput("fresh_res1", res1_top, 720);

    // Randomised play
    for (int n = 0; n < 8000; n++) begin
      bit st, ft, b1, b2;
      st = ($urandom_range(0, 399) == 0);
      ft = ($urandom_range(0, 1) == 1);
      b1 = ($urandom_range(0, 3) == 0) ? ~btn1 : btn1;
      b2 = ($urandom_range(0, 3) == 0) ? ~btn2 : btn2;
      applyStimulus(st, ft, b1, b2);
      if ($urandom_range(0, 2999) == 0) asyncReset("rndrst");
    end
    applyStimulus(0, 0, 0, 0);

    // Drain the scoreboard within a bounded wait
    for (int w = 0; w < 10 && expQ.size() > 0; w++) @(posedge clk);
    #2;
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: actual %0d pending required 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
